// File: rtl/ps2_keyboard_rx_pkg.sv
// Shared constants for the PS/2 keyboard receiver: scan codes and a parity helper.
package ps2_keyboard_rx_pkg;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  localparam logic [7:0] KP_0 = 8'h70;
  localparam logic [7:0] KP_1 = 8'h69;
  localparam logic [7:0] KP_2 = 8'h72;
  localparam logic [7:0] KP_3 = 8'h7A;
  localparam logic [7:0] KP_4 = 8'h6B;
  localparam logic [7:0] KP_5 = 8'h73;
  localparam logic [7:0] KP_6 = 8'h74;
  localparam logic [7:0] KP_7 = 8'h6C;
  localparam logic [7:0] KP_8 = 8'h75;
  localparam logic [7:0] KP_9 = 8'h7D;

  // PS/2 uses odd parity over the data byte plus the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer plus FILTER_LEN-sample deglitch for one PS/2 line.
// fall pulses for one cycle when the filtered level goes 1 -> 0.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic ck,
  input  logic reset,
  input  logic line,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN) + 1;

  logic [1:0]    sync_q;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge ck) begin
    if (reset) begin
      sync_q <= 2'b11;
      level  <= 1'b1;
      cnt    <= '0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], line};
      fall   <= 1'b0;
      // Any sample equal to the current level restarts the run of differing samples.
      if (sync_q[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        level <= sync_q[1];
        cnt   <= '0;
        fall  <= level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// Host-side PS/2 receiver: decodes 11-bit device-to-host frames into scan codes.
// Optional feature: define PS2_BREAK_FILTER_EN to fold F0-prefixed releases into a 00 code.
module ps2_keyboard_rx
  import ps2_keyboard_rx_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       ck,
  input  logic       reset,
  input  logic       PS2C,
  input  logic       PS2D,
  output logic [7:0] key_code_out,
  output logic       key_valid,
  output logic       frame_err,
  output logic [1:0] state_dbg
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          fall;
  logic [1:0]    ps2d_q;
  logic          ps2d;
  logic [1:0]    state;
  logic [7:0]    shift;
  logic [2:0]    bitcnt;
  logic          parity_bit;
  logic [TW-1:0] timer;
`ifdef PS2_BREAK_FILTER_EN
  logic          break_pending;
`endif

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .ck    (ck),
    .reset (reset),
    .line  (PS2C),
    .fall  (fall)
  );

  // Data only needs synchronizing: it is stable long before the filtered clock edge.
  always_ff @(posedge ck) begin
    if (reset) ps2d_q <= 2'b11;
    else       ps2d_q <= {ps2d_q[0], PS2D};
  end
  assign ps2d      = ps2d_q[1];
  assign state_dbg = state;

  always_ff @(posedge ck) begin
    if (reset) begin
      state        <= IDLE;
      shift        <= '0;
      bitcnt       <= '0;
      parity_bit   <= 1'b0;
      timer        <= '0;
      key_code_out <= 8'h00;
      key_valid    <= 1'b0;
      frame_err    <= 1'b0;
`ifdef PS2_BREAK_FILTER_EN
      break_pending <= 1'b0;
`endif
    end else begin
      key_valid <= 1'b0;
      frame_err <= 1'b0;
      if (state == IDLE) begin
        timer <= '0;
        // A fall with data high is a stray edge and is ignored without error.
        if (fall && !ps2d) begin
          state  <= DATA;
          bitcnt <= '0;
        end
      end else if (fall) begin
        timer <= '0;
        case (state)
          DATA: begin
            shift  <= {ps2d, shift[7:1]};
            bitcnt <= bitcnt + 1'b1;
            if (bitcnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            parity_bit <= ps2d;
            state      <= STOP;
          end
          default: begin
            state <= IDLE;
            if (ps2d && odd_parity_ok(shift, parity_bit)) begin
`ifdef PS2_BREAK_FILTER_EN
              if (shift == PS2_BREAK) begin
                break_pending <= 1'b1;
              end else if (break_pending) begin
                break_pending <= 1'b0;
                key_code_out  <= 8'h00;
                key_valid     <= 1'b1;
              end else begin
                key_code_out <= shift;
                key_valid    <= 1'b1;
              end
`else
              key_code_out <= shift;
              key_valid    <= 1'b1;
`endif
            end else begin
              frame_err <= 1'b1;
`ifdef PS2_BREAK_FILTER_EN
              break_pending <= 1'b0;
`endif
            end
          end
        endcase
      end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
        timer     <= '0;
        state     <= IDLE;
        frame_err <= 1'b1;
`ifdef PS2_BREAK_FILTER_EN
        break_pending <= 1'b0;
`endif
      end else begin
        timer <= timer + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx with a time-scaled keyboard BFM.
module tb_ps2_keyboard_rx;

  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 200;
  localparam int HALF           = 40;

  logic       ck;
  logic       reset;
  logic       ps2c;
  logic       ps2d;
  logic [7:0] key_code_out;
  logic       key_valid;
  logic       frame_err;
  logic [1:0] state_dbg;

  int checks   = 0;
  int failures = 0;
  int valid_cnt = 0;
  int err_cnt   = 0;
  int both_cnt  = 0;
  int rst_viol  = 0;

  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    bit         flip_par;
    bit         bad_stop;
    logic [7:0] exp_code;
    bit         exp_valid;
    bit         exp_err;
  } vec_t;

  vec_t vecs[$];

  ps2_keyboard_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .ck           (ck),
    .reset        (reset),
    .PS2C         (ps2c),
    .PS2D         (ps2d),
    .key_code_out (key_code_out),
    .key_valid    (key_valid),
    .frame_err    (frame_err),
    .state_dbg    (state_dbg)
  );

  // Clock and reset
  initial ck = 1'b0;
  always #10 ck = ~ck;

  // Scoreboard: every key_valid pulse must match the oldest expected code
  always @(negedge ck) begin
    if (reset) begin
      if (key_valid || frame_err) rst_viol++;
    end else begin
      if (key_valid && frame_err) both_cnt++;
      if (frame_err) err_cnt++;
      if (key_valid) begin
        valid_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_valid: got code %h, none expected", key_code_out);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (key_code_out !== e) begin
            failures++;
            $display("FAIL valid_code: got %h, expected %h", key_code_out, e);
          end
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge ck);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Driver: bits[0] goes first; each bit is a high half then a low half of PS2C.
  task automatic send_bits(input logic [10:0] bits, input int nbits, input bit glitch);
    for (int i = 0; i < nbits; i++) begin
      ps2d = bits[i];
      if (glitch) begin
        wait_cyc(10); ps2c = 1'b0; wait_cyc(5); ps2c = 1'b1; wait_cyc(HALF - 15);
      end else begin
        wait_cyc(HALF);
      end
      ps2c = 1'b0;
      if (glitch) begin
        wait_cyc(10); ps2c = 1'b1; wait_cyc(5); ps2c = 1'b0; wait_cyc(HALF - 15);
      end else begin
        wait_cyc(HALF);
      end
      ps2c = 1'b1;
    end
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] data, input bit flip_par,
                                             input bit bad_stop);
    logic par;
    par = (~^data) ^ flip_par;
    return {~bad_stop, par, data, 1'b0};
  endfunction

  task automatic run_frame(input string name, input logic [7:0] data, input bit flip_par,
                           input bit bad_stop, input bit glitch, input logic [7:0] exp_code,
                           input bit exp_valid, input bit exp_err);
    int v0, e0;
    v0 = valid_cnt;
    e0 = err_cnt;
    if (exp_valid) exp_q.push_back(exp_code);
    send_bits(make_frame(data, flip_par, bad_stop), 11, glitch);
    ps2d = 1'b1;
    check({name, "_code"}, {24'h0, key_code_out}, {24'h0, exp_code});
    check({name, "_valid_pulses"}, valid_cnt - v0, exp_valid ? 1 : 0);
    check({name, "_err_pulses"}, err_cnt - e0, exp_err ? 1 : 0);
  endtask

  initial begin
    int e0;
    reset = 1'b1;
    ps2c  = 1'b1;
    ps2d  = 1'b1;
    wait_cyc(5);
    check("reset_code", {24'h0, key_code_out}, 32'h0);
    check("reset_valid", {31'h0, key_valid}, 32'h0);
    check("reset_err", {31'h0, frame_err}, 32'h0);
    check("reset_state", {30'h0, state_dbg}, 32'h0);
    reset = 1'b0;
    wait_cyc(5);

    vecs.push_back('{8'h69, 1'b0, 1'b0, 8'h69, 1'b1, 1'b0});
    vecs.push_back('{8'h72, 1'b1, 1'b0, 8'h69, 1'b0, 1'b1});
    vecs.push_back('{8'hE0, 1'b0, 1'b0, 8'hE0, 1'b1, 1'b0});
    vecs.push_back('{8'h5A, 1'b0, 1'b1, 8'hE0, 1'b0, 1'b1});
    vecs.push_back('{8'h69, 1'b0, 1'b0, 8'h69, 1'b1, 1'b0});
`ifdef PS2_BREAK_FILTER_EN
    vecs.push_back('{8'hF0, 1'b0, 1'b0, 8'h69, 1'b0, 1'b0});
    vecs.push_back('{8'h69, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0});
    vecs.push_back('{8'hF0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
    vecs.push_back('{8'h11, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1});
`else
    vecs.push_back('{8'hF0, 1'b0, 1'b0, 8'hF0, 1'b1, 1'b0});
    vecs.push_back('{8'h69, 1'b0, 1'b0, 8'h69, 1'b1, 1'b0});
    vecs.push_back('{8'hF0, 1'b0, 1'b0, 8'hF0, 1'b1, 1'b0});
    vecs.push_back('{8'h11, 1'b1, 1'b0, 8'hF0, 1'b0, 1'b1});
`endif
    vecs.push_back('{8'h69, 1'b0, 1'b0, 8'h69, 1'b1, 1'b0});
    vecs.push_back('{8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0});
    vecs.push_back('{8'hFF, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0});

    // Frames follow each other with only the normal bit spacing (back-to-back).
    foreach (vecs[i])
      run_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].flip_par, vecs[i].bad_stop,
                1'b0, vecs[i].exp_code, vecs[i].exp_valid, vecs[i].exp_err);

    // Timeout: start + 4 data bits, then PS2C stalls high
    e0 = err_cnt;
    send_bits(make_frame(8'h7A, 1'b0, 1'b0), 5, 1'b0);
    wait_cyc(TIMEOUT_CYCLES - 100);
    check("timeout_not_early", err_cnt - e0, 0);
    check("timeout_state_busy", {30'h0, state_dbg}, 32'h1);
    wait_cyc(120);
    check("timeout_err", err_cnt - e0, 1);
    check("timeout_state_idle", {30'h0, state_dbg}, 32'h0);
    ps2d = 1'b1;
    wait_cyc(20);
    run_frame("after_timeout", 8'h7A, 1'b0, 1'b0, 1'b0, 8'h7A, 1'b1, 1'b0);

    // 100 ns glitches on PS2C in both phases of every bit
    run_frame("glitch", 8'h6B, 1'b0, 1'b0, 1'b1, 8'h6B, 1'b1, 1'b0);

    // Reset during bit 5: frame abandoned silently
    e0 = err_cnt;
    send_bits(make_frame(8'h33, 1'b0, 1'b0), 6, 1'b0);
    reset = 1'b1;
    wait_cyc(3);
    check("midreset_code", {24'h0, key_code_out}, 32'h0);
    check("midreset_state", {30'h0, state_dbg}, 32'h0);
    reset = 1'b0;
    ps2d  = 1'b1;
    wait_cyc(TIMEOUT_CYCLES + 20);
    check("midreset_no_err", err_cnt - e0, 0);
    run_frame("after_reset", 8'h69, 1'b0, 1'b0, 1'b0, 8'h69, 1'b1, 1'b0);

    wait_cyc(20);
    check("missing_valid_pulses", exp_q.size(), 0);
    check("valid_and_err_together", both_cnt, 0);
    check("pulse_during_reset", rst_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
